// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the systolic datapath sequencers and the address selector.
// Holds the FSM state encoding, the parked/last serial values and default pipeline timing.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Serial 127 selects an SRAM row that holds zeros, so parking there feeds the array nothing.
    localparam logic [6:0] SERIAL_LAST   = 7'd126;
    localparam logic [6:0] SERIAL_IDLE   = 7'd127;

    localparam int         DRAIN_CYC_DEF = 33;
    localparam int         RD_LAT_DEF    = 2;

    function automatic logic seq_is_busy(input seq_state_t st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/valid_pipe.sv
// Reset-clearable shift register delaying a 1-bit flag by DEPTH cycles (DEPTH >= 1).
// Latency DEPTH cycles; no backpressure, one sample accepted every cycle.
module valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_vld = r_pipe[DEPTH-1];

endmodule

// File: rtl/addr_seq_ctrl.sv
// Tile sequencer: start pulse -> per-tile serial sweep 0..SERIAL_LAST, array drain, loop over tiles.
// All outputs registered; start is only honoured in IDLE and is never queued.
module addr_seq_ctrl #(
    parameter logic [6:0] SERIAL_LAST = tpu_ctrl_pkg::SERIAL_LAST,
    parameter logic [6:0] SERIAL_IDLE = tpu_ctrl_pkg::SERIAL_IDLE,
    parameter int         DRAIN_CYC   = tpu_ctrl_pkg::DRAIN_CYC_DEF,
    parameter int         RD_LAT      = tpu_ctrl_pkg::RD_LAT_DEF,
    parameter int         TILE_W      = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [TILE_W-1:0] tile_num,
    output logic [6:0]        addr_serial_num,
    output logic              arr_clear,
    output logic              data_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done
);

    import tpu_ctrl_pkg::*;

    localparam int              DCW        = $clog2(DRAIN_CYC + 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [6:0]        r_serial;
    logic [6:0]        w_serial_nxt;
    logic [DCW-1:0]    r_drain_cnt;
    logic [DCW-1:0]    w_drain_cnt_nxt;
    logic [TILE_W-1:0] r_tile_idx;
    logic [TILE_W-1:0] w_tile_idx_nxt;
    logic [TILE_W-1:0] r_tile_last;
    logic [TILE_W-1:0] w_tile_last_nxt;
    logic              r_clear;
    logic              w_clear_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_run_flag;
    logic              w_dv;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_serial    <= SERIAL_IDLE;
            r_drain_cnt <= '0;
            r_tile_idx  <= '0;
            r_tile_last <= '0;
            r_clear     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_serial    <= w_serial_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_tile_idx  <= w_tile_idx_nxt;
            r_tile_last <= w_tile_last_nxt;
            r_clear     <= w_clear_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Outputs are computed one cycle early from the next state so they leave a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_serial_nxt    = SERIAL_IDLE;
        w_drain_cnt_nxt = '0;
        w_tile_idx_nxt  = r_tile_idx;
        w_tile_last_nxt = r_tile_last;
        w_clear_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_RUN;
                    w_serial_nxt    = 7'd0;
                    w_clear_nxt     = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_tile_idx_nxt  = '0;
                    w_tile_last_nxt = tile_num;
                end
            end

            ST_RUN: begin
                w_busy_nxt = 1'b1;
                if (r_serial == SERIAL_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_serial_nxt = r_serial + 7'd1;
                end
            end

            ST_DRAIN: begin
                w_busy_nxt = 1'b1;
                if (r_drain_cnt == DRAIN_LAST) begin
                    if (r_tile_idx == r_tile_last) begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Next tile starts straight out of drain with no idle bubble.
                        w_state_nxt    = ST_RUN;
                        w_serial_nxt   = 7'd0;
                        w_clear_nxt    = 1'b1;
                        w_tile_idx_nxt = r_tile_idx + TILE_W'(1);
                    end
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DCW'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Valid follows the RUN state, not the serial value, so parked cycles never look valid.
    assign w_run_flag = (r_state == ST_RUN);

    valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .srst  (srst),
        .i_vld (w_run_flag),
        .o_vld (w_dv)
    );

    assign addr_serial_num = r_serial;
    assign arr_clear       = r_clear;
    assign data_valid      = w_dv;
    assign tile_idx        = r_tile_idx;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl: expected per-cycle outputs are queued when a job is started
// and compared on the falling edge as the DUT produces them.
module tb_addr_seq_ctrl;

    localparam int TILE_CYC = 160;
    localparam int RUN_CYC  = 127;
    localparam int RDL      = 2;

    typedef struct {
        int         k;
        logic [6:0] serial;
        logic       clr;
        logic       dv;
        logic [3:0] tidx;
        logic       bsy;
        logic       dn;
    } exp_t;

    logic       clk;
    logic       srst;
    logic       start;
    logic [3:0] tile_num;
    logic [6:0] addr_serial_num;
    logic       arr_clear;
    logic       data_valid;
    logic [3:0] tile_idx;
    logic       busy;
    logic       done;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_k  = 0;

    addr_seq_ctrl u_dut (
        .clk             (clk),
        .srst            (srst),
        .start           (start),
        .tile_num        (tile_num),
        .addr_serial_num (addr_serial_num),
        .arr_clear       (arr_clear),
        .data_valid      (data_valid),
        .tile_idx        (tile_idx),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, mon_k, obs, exp_v);
        end
    endtask

    task automatic push_idle(input logic [3:0] tidx);
        exp_t e;
        e.k = -1; e.serial = 7'd127; e.clr = 1'b0; e.dv = 1'b0;
        e.tidx = tidx; e.bsy = 1'b0; e.dn = 1'b0;
        q.push_back(e);
    endtask

    // Expected outputs for cycles 1..lim after the accepting edge of an n-tile job.
    task automatic push_job(input int n, input int lim);
        exp_t e;
        int   total;
        int   p;
        int   m;
        total = (lim > 0) ? lim : n * TILE_CYC + 2;
        for (int k = 1; k <= total; k++) begin
            p = (k - 1) % TILE_CYC;
            m = k - 1 - RDL;
            e.k  = k;
            e.dv = (m >= 0) && (m < n * TILE_CYC) && ((m % TILE_CYC) < RUN_CYC);
            if (k <= n * TILE_CYC) begin
                e.serial = (p < RUN_CYC) ? 7'(p) : 7'd127;
                e.clr    = (p == 0);
                e.tidx   = 4'((k - 1) / TILE_CYC);
                e.bsy    = 1'b1;
                e.dn     = 1'b0;
            end else begin
                e.serial = 7'd127;
                e.clr    = 1'b0;
                e.tidx   = 4'(n - 1);
                e.bsy    = 1'b0;
                e.dn     = (k == n * TILE_CYC + 1);
            end
            q.push_back(e);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the accepting edge.
    task automatic accept(input logic [3:0] tn, input int lim);
        start    = 1'b1;
        tile_num = tn;
        @(posedge clk);
        #1;
        start    = 1'b0;
        tile_num = ~tn;
        push_job(int'(tn) + 1, lim);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            mon_k = e.k;
            chk("serial",     32'(addr_serial_num), 32'(e.serial));
            chk("arr_clear",  32'(arr_clear),       32'(e.clr));
            chk("data_valid", 32'(data_valid),      32'(e.dv));
            chk("tile_idx",   32'(tile_idx),        32'(e.tidx));
            chk("busy",       32'(busy),            32'(e.bsy));
            chk("done",       32'(done),            32'(e.dn));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        srst     = 1'b1;
        start    = 1'b0;
        tile_num = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        push_idle(4'd0);
        push_idle(4'd0);
        repeat (2) @(posedge clk);
        #1;

        // Single tile
        accept(4'd0, 0);
        repeat (TILE_CYC + 2) @(posedge clk);
        #1;

        // Three back-to-back tiles
        accept(4'd2, 0);
        repeat (3 * TILE_CYC + 2) @(posedge clk);
        #1;

        // Starts in RUN (cycle 50) and in the DONE cycle are ignored; cycle 162 start is taken
        accept(4'd0, 0);
        repeat (49) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (110) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        accept(4'd0, 0);
        repeat (TILE_CYC + 2) @(posedge clk);
        #1;

        // Reset during tile 1 at serial 60 (cycle 221)
        accept(4'd1, TILE_CYC + 61);
        repeat (TILE_CYC + 60) @(posedge clk);
        #1 srst = 1'b1;
        push_idle(4'd0);
        push_idle(4'd0);
        @(posedge clk);
        #1 srst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset and start together: reset wins
        srst     = 1'b1;
        start    = 1'b1;
        tile_num = 4'd5;
        @(posedge clk);
        #1;
        srst  = 1'b0;
        start = 1'b0;
        push_idle(4'd0);
        push_idle(4'd0);
        push_idle(4'd0);
        repeat (3) @(posedge clk);
        #1;

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_seq_ctrl.md
# addr_seq_ctrl

Sequencer for the 16×16 systolic datapath's address-select stage. It turns a single start pulse into the per-tile `addr_serial_num` sweep (0..126), drains the array, and loops over a programmed number of tiles. It also provides the accumulator-clear, data-valid and done/busy handshakes to the top-level controller. It sits between the top FSM and the weight/data address selector, which registers the serial number into the eight SRAM read addresses.

## Interface
Parameters:
- `SERIAL_LAST`, 126: last valid serial number of a tile sweep.
- `SERIAL_IDLE`, 127: parked serial value; the selector maps it to SRAM address 127, which holds zeros.
- `DRAIN_CYC`, 33: cycles the array needs after the last fetch before its outputs are complete.
- `RD_LAT`, 2: cycles from `addr_serial_num` to SRAM data at the array (selector register plus SRAM read).
- `TILE_W`, 4: width of the tile count and tile index.

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `srst` — in — 1 — reset, **synchronous, active-high**.
- `start` — in — 1 — start request; accepted only in IDLE.
- `tile_num` — in — TILE_W — number of tiles minus 1; sampled on the accepted `start`.
- `addr_serial_num` — out — 7 — serial number driven to the address selector.
- `arr_clear` — out — 1 — one-cycle accumulator clear at each tile's serial 0.
- `data_valid` — out — 1 — SRAM data valid at the array (in-range flag delayed by RD_LAT).
- `tile_idx` — out — TILE_W — index of the tile currently being processed.
- `busy` — out — 1 — high in RUN and DRAIN.
- `done` — out — 1 — one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- **IDLE**
  - Outputs: `addr_serial_num`=SERIAL_IDLE, `busy`=0, `done`=0, `arr_clear`=0.
  - On `start`: latch `tile_num` as `tile_last`, set `tile_idx`=0, go to RUN.
- **RUN**
  - `addr_serial_num` increments by 1 per cycle, from 0 to SERIAL_LAST.
  - `arr_clear`=1 only in the cycle where serial=0.
  - When serial=SERIAL_LAST, the next state is DRAIN and the serial parks at SERIAL_IDLE.
- **DRAIN**
  - Serial stays at SERIAL_IDLE.
  - The drain counter counts DRAIN_CYC cycles.
  - On the last drain cycle:
    - if `tile_idx`==`tile_last`, go to DONE;
    - otherwise increment `tile_idx`, go to RUN, and restart the serial at 0 (`arr_clear` fires again).
- **DONE**
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
  - `tile_idx` holds its final value until the next accepted `start`.
- `data_valid` is the flag (state==RUN) delayed by RUN_LAT-agnostic RD_LAT register stages. Its bubble behaviour is always derived from that flag, never from the serial value.
- `start` is ignored in RUN, DRAIN and DONE; there is no queuing.
- A `tile_num` change after `start` has no effect until the next job.
- Arithmetic:
  - The serial counter is 7 bits and never wraps; RUN exits at SERIAL_LAST.
  - The drain counter is sized as clog2(DRAIN_CYC+1).
  - `tile_idx` compares for equality with `tile_last`. `tile_num`=2^TILE_W−1 is legal and yields 2^TILE_W tiles.
- **Reset:** `srst` asserted in any state forces, on the next edge:
  - state IDLE;
  - serial SERIAL_IDLE;
  - `tile_idx`=0;
  - `arr_clear`, `busy`, `done` = 0;
  - `data_valid` pipeline cleared.
  
  `srst` has priority over `start` in the same cycle.

## Timing
- Reference point: `start` accepted at edge E0.
  - Cycles 1..127: RUN, serial 0..126.
  - Cycle 1: `arr_clear`=1.
- `data_valid` is high for cycles 1+RD_LAT through 127+RD_LAT.
- With default parameters, one tile takes 127 RUN cycles plus 33 DRAIN cycles (cycles 128..160). `done` is in cycle 161; IDLE resumes in cycle 162.
- Job latency from start to done = 1 + N·(127+DRAIN_CYC), where N = `tile_num`+1.
- Back-to-back tiles have no idle gap: DRAIN's last cycle is followed directly by serial 0.
- `start` asserted in the DONE cycle is ignored. `start` asserted in the first IDLE cycle after DONE is accepted.

## Structure
- Shared package `tpu_ctrl_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - SERIAL_LAST and SERIAL_IDLE, also consumed by the address selector;
  - the default DRAIN_CYC and RD_LAT.
- Sub-module `valid_pipe` (parameter DEPTH): a reset-clearable shift register producing `data_valid`. It is reusable for other datapath-alignment delays.

## Test plan
- **Single tile:** reset, `start` with `tile_num`=0.
  - Serial runs 0..126 in cycles 1..127, then 127.
  - `arr_clear` only in cycle 1.
  - `done` in cycle 161; `busy` high in cycles 1..160.
- **Three tiles:** `tile_num`=2.
  - `arr_clear` in cycles 1, 161 and 321; `tile_idx` = 0/1/2.
  - Serial restarts at 0 immediately after each drain.
  - `done` in cycle 481.
- **data_valid alignment:** `data_valid` rises in cycle 3 and falls after cycle 129. The count of valid cycles per tile is 127.
- **Start while busy:** pulse `start` in cycle 50 and in the DONE cycle; both are ignored, with no change in serial or `tile_idx`. A `start` in cycle 162 is accepted.
- **Reset mid-operation:** assert `srst` at serial=60 of tile 1.
  - Next cycle: serial 127, `tile_idx` 0, `busy` 0, and no `done`.
  - `data_valid` is 0 the cycle after reset.
- **Reset versus start:** `srst` and `start` asserted together. The block stays in IDLE and serial stays 127.
